return_stack_ctrl: RTL and testbench

//  Controller for the hardware return-address stack used in the ST stage of the multicycle CPU.

---
 rtl/return_stack_ctrl_pkg.sv | 16 +
 rtl/return_stack_ctrl_if.sv | 32 +++
 rtl/return_stack_ctrl_mem.sv | 50 +++++
 rtl/return_stack_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_return_stack_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/return_stack_ctrl_pkg.sv
// Shared definitions for the ST-stage return-address stack controller.
// Optional feature macro: RSTACK_WRAP_EN (push while full overwrites the oldest entry).
package return_stack_ctrl_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 8;

  // Encodings are fixed so they line up with the CPU control unit's decode.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PUSH_WR  = 2'd1,
    ST_POP_RD   = 2'd2,
    ST_POP_DONE = 2'd3
  } rs_state_e;

endpackage

// File: rtl/return_stack_ctrl_if.sv
// Request/response bundle between the ST stage (master) and the return-stack controller (slave).
// Optional feature macro of the controller: RSTACK_WRAP_EN.
interface return_stack_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              st_w;
  logic              st_r;
  logic [ADDR_W-1:0] push_addr;
  logic              err_clr;
  logic              ready;
  logic              done;
  logic [ADDR_W-1:0] pop_addr;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output st_w, st_r, push_addr, err_clr,
    input  ready, done, pop_addr, full, empty, count, ovf_err, unf_err
  );

  modport slave (
    input  st_w, st_r, push_addr, err_clr,
    output ready, done, pop_addr, full, empty, count, ovf_err, unf_err
  );

endinterface

// File: rtl/return_stack_ctrl_mem.sv
// Return-stack RAM (rstack_mem): DEPTH x ADDR_W, one write port, one synchronous registered read port.
// Contents are never reset; only the read register is. Optional controller macro: RSTACK_WRAP_EN.
module return_stack_ctrl_mem #(
  parameter  int ADDR_W = 32,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [ADDR_W-1:0] rd_data
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] rd_data_d;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value unless a read is issued.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= {ADDR_W{1'b0}};
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/return_stack_ctrl.sv
// Return-address stack controller: push/pop FSM, stack pointer, entry count and sticky errors.
// Optional macro RSTACK_WRAP_EN: a push while full overwrites the oldest entry instead of flagging ovf_err.
module return_stack_ctrl
  import return_stack_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input logic                clk,
  input logic                rst_n,
  return_stack_ctrl_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  rs_state_e         state_q, state_d;
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              pop_unf_q, pop_unf_d;
  logic [ADDR_W-1:0] pop_addr_q, pop_addr_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  logic              ovf_set_s;
  logic              unf_set_s;
  logic              wr_en_s;
  logic              rd_en_s;
  logic [PTR_W-1:0]  rd_addr_s;
  logic [ADDR_W-1:0] rd_data_s;

  return_stack_ctrl_mem #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_s),
    .wr_addr (sp_q),
    .wr_data (bus.push_addr),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

  // Next-state, pointer/count update and RAM control.
  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    count_d    = count_q;
    pop_unf_d  = pop_unf_q;
    pop_addr_d = pop_addr_q;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
    rd_addr_s  = sp_q - PTR_ONE;

    case (state_q)
      ST_IDLE: begin
        if (bus.st_w) begin
          state_d = ST_PUSH_WR;
          if (!full_q) begin
            wr_en_s = 1'b1;
            sp_d    = sp_q + PTR_ONE;
            count_d = count_q + CNT_ONE;
          end else begin
`ifdef RSTACK_WRAP_EN
            wr_en_s = 1'b1;
            sp_d    = sp_q + PTR_ONE;
`else
            ovf_set_s = 1'b1;
`endif
          end
        end else if (bus.st_r) begin
          state_d = ST_POP_RD;
          if (!empty_q) begin
            rd_en_s   = 1'b1;
            sp_d      = sp_q - PTR_ONE;
            count_d   = count_q - CNT_ONE;
            pop_unf_d = 1'b0;
          end else begin
            unf_set_s = 1'b1;
            pop_unf_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PUSH_WR: begin
        state_d = ST_IDLE;
      end
      ST_POP_RD: begin
        // RAM output register now holds the popped entry.
        state_d = ST_POP_DONE;
        if (pop_unf_q) begin
          pop_addr_d = {ADDR_W{1'b0}};
        end else begin
          pop_addr_d = rd_data_s;
        end
      end
      ST_POP_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sticky errors, status flags and handshake outputs.
  always_comb begin
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    // A new error in the same cycle as err_clr takes precedence.
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (bus.err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (unf_set_s) begin
      unf_d = 1'b1;
    end else if (bus.err_clr) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == {CNT_W{1'b0}});
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_PUSH_WR) || (state_d == ST_POP_DONE);
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sp_q       <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      pop_unf_q  <= 1'b0;
      pop_addr_q <= {ADDR_W{1'b0}};
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      pop_unf_q  <= pop_unf_d;
      pop_addr_q <= pop_addr_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.pop_addr = pop_addr_q;
  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.ovf_err  = ovf_q;
  assign bus.unf_err  = unf_q;

endmodule

// File: tb/tb_return_stack_ctrl.sv
// Self-checking bench for return_stack_ctrl: directed table, corner sequences and random ops vs a queue model.
// Honours RSTACK_WRAP_EN in its reference model.
module tb_return_stack_ctrl;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 8;

  logic clk;
  logic rst_n;

  return_stack_ctrl_if #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) rs ();

  return_stack_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Reference model: a plain queue, oldest entry at the front.
  logic [ADDR_W-1:0] mq[$];
  bit m_ovf;
  bit m_unf;

  typedef struct {
    bit              is_pop;
    logic [31:0]     addr;
    logic [31:0]     exp_pop;
    int              exp_cnt;
    bit              exp_empty;
    bit              exp_unf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rs.st_w = 1'b0; rs.st_r = 1'b0; rs.err_clr = 1'b0; rs.push_addr = '0;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    chk("rst_ready", rs.ready, 1); chk("rst_done", rs.done, 0);
    chk("rst_count", rs.count, 0); chk("rst_empty", rs.empty, 1);
    chk("rst_full", rs.full, 0); chk("rst_pop_addr", rs.pop_addr, 0);
    chk("rst_errs", {rs.ovf_err, rs.unf_err}, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One handshake: raise the request, wait (bounded) for done, drop it, then idle one cycle.
  task automatic xfer(input bit is_pop, input logic [31:0] a, output logic [31:0] pa);
    int lat;
    bit got;
    chk("ready_before_req", rs.ready, 1);
    if (is_pop) begin
      rs.st_r = 1'b1;
    end else begin
      rs.st_w = 1'b1; rs.push_addr = a;
    end
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (rs.done) got = 1'b1;
    end
    pa = rs.pop_addr;
    rs.st_w = 1'b0; rs.st_r = 1'b0;
    chk(is_pop ? "pop_latency" : "push_latency", lat, is_pop ? 2 : 1);
    @(negedge clk);
  endtask

  task automatic model_op(input bit is_pop, input logic [31:0] a, output logic [31:0] exp);
    exp = '0;
    if (is_pop) begin
      if (mq.size() == 0) m_unf = 1'b1;
      else exp = mq.pop_back();
    end else if (mq.size() < DEPTH) begin
      mq.push_back(a);
    end else begin
`ifdef RSTACK_WRAP_EN
      void'(mq.pop_front());
      mq.push_back(a);
`else
      m_ovf = 1'b1;
`endif
    end
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_count"}, rs.count, mq.size());
    chk({tag, "_empty"}, rs.empty, mq.size() == 0);
    chk({tag, "_full"}, rs.full, mq.size() == DEPTH);
    chk({tag, "_ovf"}, rs.ovf_err, m_ovf);
    chk({tag, "_unf"}, rs.unf_err, m_unf);
  endtask

  task automatic op_vs_model(input string tag, input bit is_pop, input logic [31:0] a);
    logic [31:0] exp, pa;
    model_op(is_pop, a, exp);
    xfer(is_pop, a, pa);
    if (is_pop) chk({tag, "_pop_addr"}, pa, exp);
    model_check(tag);
  endtask

  initial begin
    logic [31:0] pa;
    int lat;
    bit got;

    vecs[0] = '{1'b0, 32'h100, 32'h0,   1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h200, 32'h0,   2, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h300, 32'h0,   3, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'h0,   32'h300, 2, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0,   32'h200, 1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h0,   32'h100, 0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h0,   32'h0,   0, 1'b1, 1'b1};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      xfer(vecs[i].is_pop, vecs[i].addr, pa);
      if (vecs[i].is_pop) chk($sformatf("tbl%0d_pop_addr", i), pa, vecs[i].exp_pop);
      chk($sformatf("tbl%0d_count", i), rs.count, vecs[i].exp_cnt);
      chk($sformatf("tbl%0d_empty", i), rs.empty, vecs[i].exp_empty);
      chk($sformatf("tbl%0d_unf", i), rs.unf_err, vecs[i].exp_unf);
    end
    rs.err_clr = 1'b1;
    @(negedge clk);
    rs.err_clr = 1'b0;
    chk("err_clr_unf", rs.unf_err, 0);

    // err_clr in the same cycle as a pop-on-empty: the new error must survive.
    rs.err_clr = 1'b1; rs.st_r = 1'b1;
    @(negedge clk);
    rs.err_clr = 1'b0;
    chk("set_beats_clr_unf", rs.unf_err, 1);
    @(negedge clk);
    chk("set_beats_clr_done", rs.done, 1);
    rs.st_r = 1'b0;
    @(negedge clk);

    // Overflow: DEPTH+1 pushes then drain.
    do_reset();
    for (int i = 1; i <= DEPTH + 1; i++) op_vs_model("ovf_push", 1'b0, 32'(i));
`ifdef RSTACK_WRAP_EN
    chk("ovf_flag_final", rs.ovf_err, 0);
`else
    chk("ovf_flag_final", rs.ovf_err, 1);
`endif
    for (int i = 0; i < DEPTH; i++) op_vs_model("ovf_pop", 1'b1, 32'h0);

    // Simultaneous push and pop on empty: push wins, the held pop then returns it.
    do_reset();
    rs.st_w = 1'b1; rs.st_r = 1'b1; rs.push_addr = 32'hCAFE_0001;
    @(negedge clk);
    chk("both_push_done", rs.done, 1);
    chk("both_push_count", rs.count, 1);
    rs.st_w = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (rs.done) got = 1'b1;
    end
    rs.st_r = 1'b0;
    chk("both_pop_latency", lat, 3);
    chk("both_pop_addr", rs.pop_addr, 32'hCAFE_0001);
    chk("both_pop_count", rs.count, 0);
    @(negedge clk);

    // Reset while a pop is waiting on the RAM.
    op_vs_model("pre_rst_push", 1'b0, 32'h55);
    op_vs_model("pre_rst_push", 1'b0, 32'h66);
    rs.st_r = 1'b1;
    @(negedge clk);
    chk("poprd_no_done", rs.done, 0);
    rst_n = 1'b0; rs.st_r = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", rs.ready, 1);
    chk("midrst_count", rs.count, 0);
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rs.done) got = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_done", got, 0);
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;

    // Randomised operations against the queue model.
    do_reset();
    for (int n = 0; n < 200; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8) begin
        rs.err_clr = 1'b1;
        @(negedge clk);
        rs.err_clr = 1'b0;
        m_ovf = 1'b0; m_unf = 1'b0;
        model_check("rnd_clr");
      end else if (r < 57) begin
        op_vs_model("rnd_push", 1'b0, $urandom);
      end else begin
        op_vs_model("rnd_pop", 1'b1, 32'h0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
